simon_encrypt_core: RTL and testbench

SIMON_ENCRYPT_CORE -- requirements
Module: simon_encrypt_core

---
 rtl/simon_pkg.sv | 21 ++
 rtl/simon_round.sv | 24 ++
 rtl/simon_encrypt_core.sv | 89 ++++++++
 tb/tb_simon_encrypt_core.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon definitions: word/round sizing, FSM states, and the
// key schedule constants (z3 sequence and c) used by the key stage.
package simon_pkg;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 44;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // z3 sequence, Z3[i] is element i (Simon64/128 uses z3).
    localparam logic [61:0] Z3 =
        62'b11110000101100111001010001001000000111101001100011010111011011;

    // c = 2^n - 4
    localparam logic [WORD_W-1:0] SIMON_C = ~WORD_W'(3);

endpackage

// File: rtl/simon_round.sv
// One combinational Simon Feistel round.
// Ports: x, y (state words), k (round key) -> x_next, y_next.
module simon_round #(
    parameter int WORD_W = simon_pkg::WORD_W
) (
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic [WORD_W-1:0] k,
    output logic [WORD_W-1:0] x_next,
    output logic [WORD_W-1:0] y_next
);

    logic [WORD_W-1:0] rol1;
    logic [WORD_W-1:0] rol2;
    logic [WORD_W-1:0] rol8;

    assign rol1 = (x << 1) | (x >> (WORD_W - 1));
    assign rol2 = (x << 2) | (x >> (WORD_W - 2));
    assign rol8 = (x << 8) | (x >> (WORD_W - 8));

    assign x_next = y ^ (rol1 & rol8) ^ rol2 ^ k;
    assign y_next = x;

endmodule

// File: rtl/simon_encrypt_core.sv
// Iterative Simon encryption core, one round per accepted round key.
// Ports: clk, rst (async high); start/pt request; key_valid/key_in with
// key_ready and round_idx toward the key stage; busy, ct, done pulse.
module simon_encrypt_core #(
    parameter int WORD_W = simon_pkg::WORD_W,
    parameter int ROUNDS = simon_pkg::ROUNDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*WORD_W-1:0] pt,
    input  logic                key_valid,
    input  logic [WORD_W-1:0]   key_in,
    output logic                key_ready,
    output logic [7:0]          round_idx,
    output logic                busy,
    output logic [2*WORD_W-1:0] ct,
    output logic                done
);

    import simon_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

    state_t state_q;
    state_t state_d;

    logic [WORD_W-1:0] x_q;
    logic [WORD_W-1:0] y_q;
    logic [WORD_W-1:0] x_nx;
    logic [WORD_W-1:0] y_nx;
    logic              step;
    logic              last;

    assign step = (state_q == ST_RUN) && key_valid;
    assign last = (round_idx == LAST_IDX);

    simon_round #(
        .WORD_W(WORD_W)
    ) u_round (
        .x     (x_q),
        .y     (y_q),
        .k     (key_in),
        .x_next(x_nx),
        .y_next(y_nx)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (step && last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ct is captured on the final round so it is valid in the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            round_idx <= '0;
            ct        <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                x_q       <= pt[2*WORD_W-1:WORD_W];
                y_q       <= pt[WORD_W-1:0];
                round_idx <= '0;
            end
            if (step) begin
                x_q <= x_nx;
                y_q <= y_nx;
                if (last) ct <= {x_nx, y_nx};
                else      round_idx <= round_idx + 8'd1;
            end
        end
    end

    assign key_ready = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_simon_encrypt_core.sv
// Scoreboard bench for simon_encrypt_core: Simon64/128 known answer,
// stalls, ignored start, mid-run reset, back-to-back and idle keys.
module tb_simon_encrypt_core;

    import simon_pkg::*;

    localparam int R = 44;
    localparam logic [63:0] PT_KAT = 64'h656b696c_20646e75;
    localparam logic [63:0] CT_KAT = 64'h44c8fc20_b9dfa07a;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] pt = '0;
    logic        key_valid = 1'b0;
    logic [31:0] key_in;
    logic        key_ready;
    logic [7:0]  round_idx;
    logic        busy;
    logic [63:0] ct;
    logic        done;

    logic [31:0] rk [R];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] ct;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    simon_encrypt_core #(.WORD_W(32), .ROUNDS(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pt       (pt),
        .key_valid(key_valid),
        .key_in   (key_in),
        .key_ready(key_ready),
        .round_idx(round_idx),
        .busy     (busy),
        .ct       (ct),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key stage stand-in: serves the key for the round the core asks for.
    assign key_in = (round_idx < 8'(R)) ? rk[int'(round_idx)] : '0;

    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d want none",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ct", ct, e.ct);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_in_done", {63'b0, busy}, 64'd1);
                chk("key_ready_in_done", {63'b0, key_ready}, 64'd0);
                chk("round_idx_bound", {63'b0, round_idx <= 8'(R - 1)}, 64'd1);
            end
        end
    end

    task automatic wait_idle(input string nm);
        int g;
        g = 0;
        while (busy && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 300) chk({nm, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic run_op(input bit stall, input bit poke, input int rst_round);
        int t;
        int g;
        bit poked;
        logic [255:0] stalled;
        poked = 1'b0;
        stalled = '0;
        @(posedge clk); #1;
        pt = PT_KAT;
        start = 1'b1;
        t = cyc;
        if (rst_round < 0)
            sb.push_back('{ct: CT_KAT, cyc: t + 45 + (stall ? 15 : 0)});
        @(posedge clk); #1;
        start = 1'b0;
        g = 0;
        while (busy && g < 300) begin
            g++;
            if (rst_round >= 0 && round_idx == 8'(rst_round)) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", {63'b0, busy}, 64'd0);
                chk("rst_ct", ct, 64'd0);
                chk("rst_done", {63'b0, done}, 64'd0);
                chk("rst_round_idx", {56'b0, round_idx}, 64'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (stall && key_ready && !stalled[round_idx] &&
                (round_idx == 8'd3 || round_idx == 8'd20 ||
                 round_idx == 8'd43)) begin
                logic [7:0] r;
                r = round_idx;
                stalled[r] = 1'b1;
                key_valid = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("stall_hold", {56'b0, round_idx}, {56'b0, r});
                end
                key_valid = 1'b1;
                continue;
            end
            if (poke && !poked && key_ready && round_idx == 8'd10) begin
                poked = 1'b1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                continue;
            end
            @(posedge clk); #1;
        end
        if (g >= 300) chk("op_timeout", 64'd1, 64'd0);
    endtask

    task automatic back_to_back();
        int t;
        int g;
        @(posedge clk); #1;
        pt = PT_KAT;
        start = 1'b1;
        t = cyc;
        sb.push_back('{ct: CT_KAT, cyc: t + 45});
        @(posedge clk); #1;
        start = 1'b0;
        g = 0;
        while (done !== 1'b1 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) chk("b2b_timeout", 64'd1, 64'd0);
        // Raised in the done cycle (ignored), held into the IDLE cycle.
        start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_idle_gap", {63'b0, busy}, 64'd0);
        sb.push_back('{ct: CT_KAT, cyc: cyc + 45});
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accepted", {63'b0, busy}, 64'd1);
        wait_idle("b2b");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp;
        rk[0] = 32'h03020100;
        rk[1] = 32'h0b0a0908;
        rk[2] = 32'h13121110;
        rk[3] = 32'h1b1a1918;
        for (int i = 4; i < R; i++) begin
            tmp = ror(rk[i-1], 3) ^ rk[i-3];
            tmp = tmp ^ ror(tmp, 1);
            rk[i] = SIMON_C ^ {31'b0, Z3[i-4]} ^ rk[i-4] ^ tmp;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ct", ct, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_key_ready", {63'b0, key_ready}, 64'd0);
        chk("reset_round_idx", {56'b0, round_idx}, 64'd0);
        rst = 1'b0;

        key_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_key_ready", {63'b0, key_ready}, 64'd0);
            chk("idle_busy", {63'b0, busy}, 64'd0);
        end

        run_op(1'b0, 1'b0, 30);
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_idle", {63'b0, busy}, 64'd0);
        end
        chk("post_rst_ct", ct, 64'd0);

        run_op(1'b0, 1'b0, -1);
        run_op(1'b1, 1'b0, -1);
        run_op(1'b0, 1'b1, -1);
        back_to_back();

        repeat (3) @(posedge clk);
        #1;
        chk("ct_held", ct, CT_KAT);
        chk("missing_done", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
